// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state encodings, BYPASS opcode and the
// TAP next-state function.
package jtag_tap_pkg;

    typedef logic [3:0] tap_state_t;

    localparam tap_state_t EXIT2_DR         = 4'h0;
    localparam tap_state_t EXIT1_DR         = 4'h1;
    localparam tap_state_t SHIFT_DR         = 4'h2;
    localparam tap_state_t PAUSE_DR         = 4'h3;
    localparam tap_state_t SELECT_IR_SCAN   = 4'h4;
    localparam tap_state_t UPDATE_DR        = 4'h5;
    localparam tap_state_t CAPTURE_DR       = 4'h6;
    localparam tap_state_t SELECT_DR_SCAN   = 4'h7;
    localparam tap_state_t EXIT2_IR         = 4'h8;
    localparam tap_state_t EXIT1_IR         = 4'h9;
    localparam tap_state_t SHIFT_IR         = 4'hA;
    localparam tap_state_t PAUSE_IR         = 4'hB;
    localparam tap_state_t RUN_TEST_IDLE    = 4'hC;
    localparam tap_state_t UPDATE_IR        = 4'hD;
    localparam tap_state_t CAPTURE_IR       = 4'hE;
    localparam tap_state_t TEST_LOGIC_RESET = 4'hF;

    // All-ones opcode; slice to the IR width at the point of use.
    localparam logic [31:0] IR_BYPASS = '1;

    function automatic tap_state_t next_tap_state(input tap_state_t state, input logic tms);
        tap_state_t nxt;
        unique case (state)
            TEST_LOGIC_RESET: nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   nxt = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       nxt = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         nxt = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         nxt = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         nxt = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         nxt = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       nxt = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         nxt = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         nxt = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         nxt = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         nxt = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          nxt = TEST_LOGIC_RESET;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP state register; advances one IEEE 1149.1 step per cycle with advance_i high.
module jtag_tap_fsm
    import jtag_tap_pkg::*;
(
    input  logic       system_clk,
    input  logic       rst_i,
    input  logic       advance_i,
    input  logic       tms_i,
    output tap_state_t state_o,
    output tap_state_t next_state_o
);

    tap_state_t state_q;
    tap_state_t state_d;

    always_comb begin
        state_d = state_q;
        if (advance_i) begin
            state_d = next_tap_state(state_q, tms_i);
        end
    end

    always_ff @(posedge system_clk) begin
        if (rst_i) begin
            state_q <= TEST_LOGIC_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o      = state_q;
    assign next_state_o = state_d;

endmodule

// File: rtl/jtag_tap_oversampled.sv
// JTAG TAP running entirely on system_clk; TCK is oversampled and edge-detected.
// Define JTAG_TAP_OVERSAMPLED_INPUT_SYNC_EN to add two-flop input synchronizers.
module jtag_tap_oversampled
    import jtag_tap_pkg::*;
#(
    parameter int unsigned         IR_WIDTH     = 4,
    parameter logic [31:0]         IDCODE_VALUE = 32'h149511C3,
    parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = 4'h2,
    parameter logic [IR_WIDTH-1:0] USER_INSTR   = 4'h8
) (
    input  logic                system_clk,
    input  logic                system_rst,
    input  logic                jtag_tck_i,
    input  logic                jtag_tms_i,
    input  logic                jtag_trst_i,
    input  logic                jtag_tdi_i,
    output logic                jtag_tdo_o,
    output logic [3:0]          tap_state_o,
    output logic [IR_WIDTH-1:0] ir_o,
    output logic                user_sel_o,
    output logic                user_capture_o,
    output logic                user_shift_o,
    output logic                user_update_o,
    output logic                user_tdi_o,
    input  logic                user_tdo_i
);

    logic tck_s, tms_s, tdi_s, trst_s;

`ifdef JTAG_TAP_OVERSAMPLED_INPUT_SYNC_EN
    logic [3:0] sync1_q, sync2_q;

    always_ff @(posedge system_clk) begin
        if (system_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {jtag_trst_i, jtag_tdi_i, jtag_tms_i, jtag_tck_i};
            sync2_q <= sync1_q;
        end
    end

    assign {trst_s, tdi_s, tms_s, tck_s} = sync2_q;
`else
    assign tck_s  = jtag_tck_i;
    assign tms_s  = jtag_tms_i;
    assign tdi_s  = jtag_tdi_i;
    assign trst_s = jtag_trst_i;
`endif

    logic       tap_rst;
    logic       tck_q;
    logic       rise, fall;
    tap_state_t state, next_state;

    assign tap_rst = system_rst | trst_s;
    assign rise    = tck_s & ~tck_q;
    assign fall    = ~tck_s & tck_q;

    jtag_tap_fsm u_fsm (
        .system_clk   (system_clk),
        .rst_i        (tap_rst),
        .advance_i    (rise),
        .tms_i        (tms_s),
        .state_o      (state),
        .next_state_o (next_state)
    );

    logic [IR_WIDTH-1:0] ir_shift_q, ir_q;
    logic [31:0]         idcode_q;
    logic                bypass_q, tdo_q, tdo_d;
    logic                user_capture_q, user_shift_q, user_update_q, user_tdi_q;
    logic                sel_idcode, sel_user;

    // Anything that is neither IDCODE nor USER falls through to BYPASS.
    assign sel_idcode = (ir_q == IDCODE_INSTR);
    assign sel_user   = (ir_q == USER_INSTR);

    always_comb begin
        tdo_d = 1'b0;
        if (state == SHIFT_IR) begin
            tdo_d = ir_shift_q[0];
        end else if (state == SHIFT_DR) begin
            tdo_d = sel_user ? user_tdo_i : (sel_idcode ? idcode_q[0] : bypass_q);
        end
    end

    always_ff @(posedge system_clk) begin
        if (tap_rst) begin
            tck_q          <= 1'b0;
            ir_shift_q     <= '0;
            ir_q           <= IDCODE_INSTR;
            idcode_q       <= '0;
            bypass_q       <= 1'b0;
            tdo_q          <= 1'b0;
            user_capture_q <= 1'b0;
            user_shift_q   <= 1'b0;
            user_update_q  <= 1'b0;
            user_tdi_q     <= 1'b0;
        end else begin
            tck_q          <= tck_s;
            user_capture_q <= 1'b0;
            user_shift_q   <= 1'b0;
            user_update_q  <= 1'b0;
            if (rise) begin
                case (state)
                    CAPTURE_IR: ir_shift_q <= IR_WIDTH'(1);
                    SHIFT_IR:   ir_shift_q <= {tdi_s, ir_shift_q[IR_WIDTH-1:1]};
                    CAPTURE_DR: begin
                        if (sel_idcode) begin
                            idcode_q <= IDCODE_VALUE;
                        end else if (sel_user) begin
                            user_capture_q <= 1'b1;
                        end else begin
                            bypass_q <= 1'b0;
                        end
                    end
                    SHIFT_DR: begin
                        if (sel_user) begin
                            user_shift_q <= 1'b1;
                            user_tdi_q   <= tdi_s;
                        end else if (sel_idcode) begin
                            idcode_q <= {tdi_s, idcode_q[31:1]};
                        end else begin
                            bypass_q <= tdi_s;
                        end
                    end
                    default: ;
                endcase
                if (next_state == TEST_LOGIC_RESET) begin
                    ir_q <= IDCODE_INSTR;
                end
            end
            if (fall) begin
                if (state == UPDATE_IR) begin
                    ir_q <= ir_shift_q;
                end
                if (state == UPDATE_DR && sel_user) begin
                    user_update_q <= 1'b1;
                end
                tdo_q <= tdo_d;
            end
        end
    end

    assign jtag_tdo_o     = tdo_q;
    assign tap_state_o    = state;
    assign ir_o           = ir_q;
    assign user_sel_o     = sel_user;
    assign user_capture_o = user_capture_q;
    assign user_shift_o   = user_shift_q;
    assign user_update_o  = user_update_q;
    assign user_tdi_o     = user_tdi_q;

endmodule

// File: tb/tb_jtag_tap_oversampled.sv
// Directed bench for jtag_tap_oversampled; honours JTAG_TAP_OVERSAMPLED_INPUT_SYNC_EN.
module tb_jtag_tap_oversampled;

`ifdef JTAG_TAP_OVERSAMPLED_INPUT_SYNC_EN
    localparam int SyncDelay = 2;
`else
    localparam int SyncDelay = 0;
`endif
    localparam int Half = 4;

    logic       system_clk = 1'b0;
    logic       system_rst = 1'b1;
    logic       tck = 1'b0, tms = 1'b0, trst = 1'b0, tdi = 1'b0, user_tdo = 1'b0;
    logic       tdo;
    logic [3:0] tap_state;
    logic [3:0] ir;
    logic       user_sel, user_capture, user_shift, user_update, user_tdi;

    int checks = 0;
    int errors = 0;

    jtag_tap_oversampled dut (
        .system_clk     (system_clk),
        .system_rst     (system_rst),
        .jtag_tck_i     (tck),
        .jtag_tms_i     (tms),
        .jtag_trst_i    (trst),
        .jtag_tdi_i     (tdi),
        .jtag_tdo_o     (tdo),
        .tap_state_o    (tap_state),
        .ir_o           (ir),
        .user_sel_o     (user_sel),
        .user_capture_o (user_capture),
        .user_shift_o   (user_shift),
        .user_update_o  (user_update),
        .user_tdi_o     (user_tdi),
        .user_tdo_i     (user_tdo)
    );

    always #5 system_clk = ~system_clk;

    // Pulse monitor: running counts, shifted-bit history and width violations.
    int   cap_cnt = 0, shift_cnt = 0, upd_cnt = 0, wide_cnt = 0;
    logic tdi_hist [0:1023];
    logic prev_cap = 1'b0, prev_shift = 1'b0, prev_upd = 1'b0;

    always @(negedge system_clk) begin
        if (user_capture) cap_cnt++;
        if (user_update) upd_cnt++;
        if (user_shift) begin
            tdi_hist[shift_cnt % 1024] = user_tdi;
            shift_cnt++;
        end
        if ((user_capture && prev_cap) || (user_shift && prev_shift) || (user_update && prev_upd))
            wide_cnt++;
        prev_cap   = user_capture;
        prev_shift = user_shift;
        prev_upd   = user_update;
    end

    task automatic tck_cycle(input logic t_ms, input logic t_di);
        @(negedge system_clk);
        tms = t_ms;
        tdi = t_di;
        tck = 1'b1;
        repeat (Half + SyncDelay) @(negedge system_clk);
        tck = 1'b0;
        repeat (Half + SyncDelay) @(negedge system_clk);
    endtask

    // From RUN_TEST_IDLE, scan val into IR LSB first and return to RUN_TEST_IDLE.
    task automatic load_ir(input logic [3:0] val);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tck_cycle(i == 3, val[i]);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
    endtask

    task automatic test_reset;
        tck = 1'b0;
        repeat (2) @(negedge system_clk);
        system_rst = 1'b0;
        repeat (1 + SyncDelay) @(negedge system_clk);
        checks++;
        if (tap_state !== 4'hF) begin
            errors++; $display("FAIL rst_state got %h want f", tap_state);
        end
        checks++;
        if ({user_capture, user_shift, user_update, user_tdi} !== 4'b0) begin
            errors++; $display("FAIL rst_user got %b want 0000",
                               {user_capture, user_shift, user_update, user_tdi});
        end
        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
        checks++;
        if (tap_state !== 4'hF) begin
            errors++; $display("FAIL tlr_state got %h want f", tap_state);
        end
        checks++;
        if (ir !== 4'h2) begin
            errors++; $display("FAIL tlr_ir got %h want 2", ir);
        end
        checks++;
        if (tdo !== 1'b0) begin
            errors++; $display("FAIL tlr_tdo got %b want 0", tdo);
        end
    endtask

    task automatic test_idcode;
        logic [31:0] obs;
        obs = '0;
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        checks++;
        if (tap_state !== 4'h2) begin
            errors++; $display("FAIL idc_shiftdr got %h want 2", tap_state);
        end
        for (int i = 0; i < 32; i++) begin
            obs[i] = tdo;
            tck_cycle(i == 31, 1'b0);
        end
        checks++;
        if (obs !== 32'h149511C3) begin
            errors++; $display("FAIL idcode got %h want 149511c3", obs);
        end
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        checks++;
        if (tap_state !== 4'hC) begin
            errors++; $display("FAIL idc_rti got %h want c", tap_state);
        end
    endtask

    task automatic test_ir_bypass;
        logic [3:0] ir_obs;
        logic [4:0] pat, by_obs;
        ir_obs = '0;
        by_obs = '0;
        pat    = 5'b01101;  // applied LSB first: 1,0,1,1,0
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        checks++;
        if (tap_state !== 4'hA) begin
            errors++; $display("FAIL ir_shiftir got %h want a", tap_state);
        end
        for (int i = 0; i < 4; i++) begin
            ir_obs[i] = tdo;
            tck_cycle(i == 3, 1'b1);
        end
        checks++;
        if (ir_obs !== 4'b0001) begin
            errors++; $display("FAIL ir_capture got %b want 0001", ir_obs);
        end
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        checks++;
        if (ir !== 4'hF) begin
            errors++; $display("FAIL ir_update got %h want f", ir);
        end
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            by_obs[i] = tdo;
            tck_cycle(i == 4, pat[i]);
        end
        checks++;
        if (by_obs !== 5'b11010) begin
            errors++; $display("FAIL bypass got %b want 11010 (lsb first 0,1,0,1,1)", by_obs);
        end
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
    endtask

    task automatic test_user;
        logic [7:0] data, seq;
        int         cap0, sh0, up0;
        data = 8'hA5;
        load_ir(4'h8);
        checks++;
        if (ir !== 4'h8 || user_sel !== 1'b1) begin
            errors++; $display("FAIL user_ir got ir=%h sel=%b want ir=8 sel=1", ir, user_sel);
        end
        cap0 = cap_cnt; sh0 = shift_cnt; up0 = upd_cnt;
        user_tdo = 1'b1;
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        checks++;
        if (tdo !== 1'b1) begin
            errors++; $display("FAIL user_tdo got %b want 1", tdo);
        end
        for (int i = 0; i < 8; i++) tck_cycle(i == 7, data[i]);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        user_tdo = 1'b0;
        for (int i = 0; i < 8; i++) seq[i] = tdi_hist[(sh0 + i) % 1024];
        checks++;
        if (cap_cnt - cap0 != 1) begin
            errors++; $display("FAIL user_capture got %0d want 1", cap_cnt - cap0);
        end
        checks++;
        if (shift_cnt - sh0 != 8) begin
            errors++; $display("FAIL user_shift got %0d want 8", shift_cnt - sh0);
        end
        checks++;
        if (seq !== 8'hA5) begin
            errors++; $display("FAIL user_tdi_seq got %h want a5", seq);
        end
        checks++;
        if (upd_cnt - up0 != 1) begin
            errors++; $display("FAIL user_update got %0d want 1", upd_cnt - up0);
        end
        checks++;
        if (wide_cnt != 0) begin
            errors++; $display("FAIL pulse_width got %0d wide pulses want 0", wide_cnt);
        end
    endtask

    task automatic test_idle;
        int total0;
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        total0 = cap_cnt + shift_cnt + upd_cnt;
        for (int i = 0; i < 100; i++) begin
            @(negedge system_clk);
            tms = i[0];
            tdi = i[1];
        end
        repeat (2 + SyncDelay) @(negedge system_clk);
        checks++;
        if (tap_state !== 4'h2) begin
            errors++; $display("FAIL idle_state got %h want 2", tap_state);
        end
        checks++;
        if (cap_cnt + shift_cnt + upd_cnt != total0) begin
            errors++; $display("FAIL idle_pulses got %0d want 0", cap_cnt + shift_cnt + upd_cnt - total0);
        end
    endtask

    task automatic test_trst;
        int sh0, up0;
        tck_cycle(1'b0, 1'b1);
        tck_cycle(1'b0, 1'b0);
        sh0 = shift_cnt; up0 = upd_cnt;
        @(negedge system_clk);
        trst = 1'b1;
        tck  = 1'b1;
        tms  = 1'b1;
        tdi  = 1'b1;
        repeat (Half + SyncDelay) @(negedge system_clk);
        tck = 1'b0;
        repeat (2 + SyncDelay) @(negedge system_clk);
        trst = 1'b0;
        repeat (Half + SyncDelay) @(negedge system_clk);
        checks++;
        if (tap_state !== 4'hF) begin
            errors++; $display("FAIL trst_state got %h want f", tap_state);
        end
        checks++;
        if (ir !== 4'h2) begin
            errors++; $display("FAIL trst_ir got %h want 2", ir);
        end
        checks++;
        if (upd_cnt != up0 || shift_cnt != sh0) begin
            errors++; $display("FAIL trst_pulses got upd=%0d shift=%0d want 0 0",
                               upd_cnt - up0, shift_cnt - sh0);
        end
        checks++;
        if (tdo !== 1'b0) begin
            errors++; $display("FAIL trst_tdo got %b want 0", tdo);
        end
    endtask

    task automatic test_latency;
        int n;
        n = 0;
        @(negedge system_clk);
        tms = 1'b0;
        tck = 1'b1;
        while (tap_state !== 4'hC && n < 10) begin
            @(posedge system_clk);
            #1;
            n++;
        end
        checks++;
        if (n != 1 + SyncDelay) begin
            errors++; $display("FAIL latency got %0d cycles want %0d", n, 1 + SyncDelay);
        end
        @(negedge system_clk);
        tck = 1'b0;
        repeat (Half + SyncDelay) @(negedge system_clk);
    endtask

    // From SHIFT_DR with USER loaded, five TMS=1 rises must land in TEST_LOGIC_RESET.
    task automatic test_five_tms;
        load_ir(4'h8);
        tck_cycle(1'b1, 1'b0);
        tck_cycle(1'b0, 1'b0);
        tck_cycle(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
        checks++;
        if (tap_state !== 4'hF || ir !== 4'h2) begin
            errors++; $display("FAIL five_tms got state=%h ir=%h want f 2", tap_state, ir);
        end
    endtask

    initial begin
        test_reset();
        test_idcode();
        test_ir_bypass();
        test_user();
        test_idle();
        test_trst();
        test_latency();
        test_five_tms();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1);
    end

endmodule
